// File: rtl/sponge_pkg.sv
// Shared sponge types and helpers, used by the absorb and squeeze stages.
package sponge_pkg;

  localparam int SPONGE_CWIDTH = 320;
  localparam int SPONGE_RWIDTH = 32;
  localparam int SPONGE_LENW   = $clog2(SPONGE_RWIDTH + 1);

  typedef enum logic [2:0] {
    ABS_IDLE     = 3'd0,
    ABS_WAIT_BLK = 3'd1,
    ABS_PERM     = 3'd2,
    ABS_PAD      = 3'd3,
    ABS_OUTPUT   = 3'd4
  } absorb_state_t;

  // Keeps the top len message bits, appends a single 1, zeroes the rest.
  // A length of RWIDTH or more leaves the block untouched; that pad goes in a block of its own.
  function automatic logic [SPONGE_RWIDTH-1:0] pad_block(
    input logic [SPONGE_RWIDTH-1:0] blk,
    input logic [SPONGE_LENW-1:0]   len
  );
    logic [SPONGE_RWIDTH-1:0] res;
    res = '0;
    if (int'(len) >= SPONGE_RWIDTH) begin
      res = blk;
    end else begin
      for (int i = 0; i < SPONGE_RWIDTH; i++) begin
        if (i < int'(len))
          res[SPONGE_RWIDTH-1-i] = blk[SPONGE_RWIDTH-1-i];
        else if (i == int'(len))
          res[SPONGE_RWIDTH-1-i] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sponge_absorb.sv
// Absorb phase: XORs padded message blocks into the rate, runs the external
// permutation after each one, then hands {rate,capacity} to the squeeze stage.
module sponge_absorb
  import sponge_pkg::*;
#(
  parameter int CWIDTH      = SPONGE_CWIDTH,
  parameter int RWIDTH      = SPONGE_RWIDTH,
  parameter int REMAINWIDTH = 20,
  parameter int ROUND_COUNT = 10,
  parameter logic [CWIDTH+RWIDTH-1:0] IV = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [REMAINWIDTH-1:0]       out_bits,
  input  logic [ROUND_COUNT-1:0]       rounds,
  input  logic [RWIDTH-1:0]            msg_data,
  input  logic                         msg_valid,
  input  logic                         msg_last,
  input  logic [$clog2(RWIDTH+1)-1:0]  msg_len,
  output logic                         msg_ready,
  output logic                         perm_go,
  output logic [CWIDTH+RWIDTH-1:0]     perm_state,
  output logic [ROUND_COUNT-1:0]       perm_rounds,
  input  logic [CWIDTH+RWIDTH-1:0]     perm_result,
  input  logic                         perm_done,
  output logic [RWIDTH-1:0]            r_out,
  output logic [CWIDTH-1:0]            c_out,
  output logic [REMAINWIDTH-1:0]       remaining,
  output logic                         state_valid,
  input  logic                         squeeze_ack,
  output logic                         busy
);

  localparam int LENW = $clog2(RWIDTH + 1);
  localparam logic [LENW-1:0]   FULL_LEN = LENW'(RWIDTH);
  localparam logic [RWIDTH-1:0] PAD_BIT  = {1'b1, {(RWIDTH-1){1'b0}}};

  absorb_state_t          r_state;
  logic [RWIDTH-1:0]      r_rate;
  logic [CWIDTH-1:0]      r_cap;
  logic [REMAINWIDTH-1:0] r_remaining;
  logic [ROUND_COUNT-1:0] r_rounds;
  logic                   r_need_pad;
  logic                   r_final;

  logic                   w_in_perm;
  logic                   w_in_out;
  logic                   w_full_last;
  logic [RWIDTH-1:0]      w_blk;

  // Handshakes: a block moves when msg_valid & msg_ready at a rising edge;
  // perm_go stays high until perm_done is seen, the result loads on that edge;
  // state_valid stays high until squeeze_ack is seen.
  assign w_in_perm   = (r_state == ABS_PERM);
  assign w_in_out    = (r_state == ABS_OUTPUT);
  assign w_full_last = (msg_len >= FULL_LEN);
  assign w_blk       = msg_last ? pad_block(msg_data, msg_len) : msg_data;

  assign msg_ready   = (r_state == ABS_WAIT_BLK);
  assign perm_go     = w_in_perm;
  assign perm_state  = w_in_perm ? {r_rate, r_cap} : '0;
  assign perm_rounds = r_rounds;
  assign state_valid = w_in_out;
  assign r_out       = w_in_out ? r_rate : '0;
  assign c_out       = w_in_out ? r_cap : '0;
  assign remaining   = w_in_out ? r_remaining : '0;
  assign busy        = (r_state != ABS_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= ABS_IDLE;
      {r_rate, r_cap}     <= IV;
      r_remaining         <= '0;
      r_rounds            <= '0;
      r_need_pad          <= 1'b0;
      r_final             <= 1'b0;
    end else begin
      case (r_state)
        ABS_IDLE: begin
          if (start) begin
            {r_rate, r_cap} <= IV;
            r_remaining     <= out_bits;
            r_rounds        <= rounds;
            r_need_pad      <= 1'b0;
            r_final         <= 1'b0;
            r_state         <= ABS_WAIT_BLK;
          end
        end
        ABS_WAIT_BLK: begin
          if (msg_valid) begin
            r_rate <= r_rate ^ w_blk;
            if (msg_last) begin
              if (w_full_last) r_need_pad <= 1'b1;
              else             r_final    <= 1'b1;
            end
            r_state <= ABS_PERM;
          end
        end
        ABS_PERM: begin
          if (perm_done) begin
            {r_rate, r_cap} <= perm_result;
            if (r_need_pad)   r_state <= ABS_PAD;
            else if (r_final) r_state <= ABS_OUTPUT;
            else              r_state <= ABS_WAIT_BLK;
          end
        end
        ABS_PAD: begin
          // Full last block: the padding bit gets a block and a permutation of its own.
          r_rate     <= r_rate ^ PAD_BIT;
          r_need_pad <= 1'b0;
          r_final    <= 1'b1;
          r_state    <= ABS_PERM;
        end
        ABS_OUTPUT: begin
          if (squeeze_ack) r_state <= ABS_IDLE;
        end
        default: r_state <= ABS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sponge_absorb.sv
// Bench for sponge_absorb: directed cases plus random messages checked
// against a message-level sponge model and a behavioural permutation.
module tb_sponge_absorb;

  localparam int CW = 320;
  localparam int RW = 32;
  localparam int REMW = 20;
  localparam int RC = 10;
  localparam int LW = 6;
  localparam int SW = CW + RW;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [REMW-1:0] out_bits;
  logic [RC-1:0]   rounds;
  logic [RW-1:0]   msg_data;
  logic            msg_valid;
  logic            msg_last;
  logic [LW-1:0]   msg_len;
  logic            msg_ready;
  logic            perm_go;
  logic [SW-1:0]   perm_state;
  logic [RC-1:0]   perm_rounds;
  logic [SW-1:0]   perm_result;
  logic            perm_done;
  logic [RW-1:0]   r_out;
  logic [CW-1:0]   c_out;
  logic [REMW-1:0] remaining;
  logic            state_valid;
  logic            squeeze_ack;
  logic            busy;

  sponge_absorb dut (
    .clk(clk), .reset(reset), .start(start), .out_bits(out_bits), .rounds(rounds),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_len(msg_len),
    .msg_ready(msg_ready), .perm_go(perm_go), .perm_state(perm_state),
    .perm_rounds(perm_rounds), .perm_result(perm_result), .perm_done(perm_done),
    .r_out(r_out), .c_out(c_out), .remaining(remaining), .state_valid(state_valid),
    .squeeze_ack(squeeze_ack), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int perm_lat = 3;
  bit perm_rot = 1'b0;
  bit spur_en = 1'b0;
  int perm_cnt = 0;
  int acc_cnt = 0;
  logic [RC-1:0]   seen_rounds = '0;
  logic [RW-1:0]   last_r;
  logic [RW-1:0]   blk_q[$];
  logic [SW-1:0]   exp_q[$];

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // behavioural model
  function automatic logic [SW-1:0] ref_perm(input logic [SW-1:0] s);
    return perm_rot ? {s[SW-6:0], s[SW-1:SW-5]} : s;
  endfunction

  function automatic logic [RW-1:0] ref_pad(input logic [RW-1:0] b, input int len);
    logic [63:0] m;
    if (len >= RW) return b;
    m = 64'hFFFF_FFFF << (RW - len);
    return (b & m[RW-1:0]) | (32'h8000_0000 >> len);
  endfunction

  function automatic logic [SW-1:0] ref_absorb(input int len);
    logic [SW-1:0] s;
    logic [RW-1:0] b;
    s = '0;
    for (int i = 0; i < blk_q.size(); i++) begin
      b = blk_q[i];
      if (i == blk_q.size() - 1) b = ref_pad(b, len);
      s[SW-1 -: RW] = s[SW-1 -: RW] ^ b;
      s = ref_perm(s);
    end
    if (len >= RW) begin
      s[SW-1] = ~s[SW-1];
      s = ref_perm(s);
    end
    return s;
  endfunction

  // permutation responder; optionally fires perm_done while perm_go is low
  initial begin
    int cnt;
    cnt = 0;
    perm_done = 1'b0;
    perm_result = '0;
    forever begin
      @(negedge clk);
      if (perm_go) begin
        cnt++;
        if (cnt >= perm_lat) begin
          perm_done = 1'b1;
          perm_result = ref_perm(perm_state);
          seen_rounds = perm_rounds;
          perm_cnt++;
          cnt = 0;
        end else begin
          perm_done = 1'b0;
        end
      end else begin
        cnt = 0;
        perm_done = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
        perm_result = {11{$urandom}};
      end
    end
  end

  always @(posedge clk) if (msg_valid && msg_ready) acc_cnt++;

  // driver tasks
  task automatic start_msg(input logic [REMW-1:0] ob, input logic [RC-1:0] rn);
    start = 1'b1;
    out_bits = ob;
    rounds = rn;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_msg(input int len, input logic [REMW-1:0] ob, input logic [RC-1:0] rn,
                         input int ack_delay, input bit hold, input bit poke_start);
    int base_p, base_a, n, t;
    logic [SW-1:0] e;
    n = blk_q.size();
    exp_q.push_back(ref_absorb(len));
    base_p = perm_cnt;
    base_a = acc_cnt;
    start_msg(ob, rn);
    for (int i = 0; i < n; i++) begin
      msg_data = blk_q[i];
      msg_last = (i == n - 1);
      msg_len = (i == n - 1) ? LW'(len) : LW'($urandom_range(0, 63));
      msg_valid = 1'b1;
      t = 0;
      while (!msg_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!msg_ready) check("blk_ready_timeout", SW'(msg_ready), SW'(1));
      @(negedge clk);
      if (!(hold && i == n - 1)) msg_valid = 1'b0;
    end
    if (poke_start) begin
      start = 1'b1;
      out_bits = ~ob;
      rounds = ~rn;
      @(negedge clk);
      start = 1'b0;
      check("poke_perm_go", SW'(perm_go), SW'(1));
      check("poke_busy", SW'(busy), SW'(1));
    end
    t = 0;
    while (!state_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("state_valid", SW'(state_valid), SW'(1));
    msg_valid = 1'b0;
    e = exp_q.pop_front();
    last_r = r_out;
    check("r_out", SW'(r_out), SW'(e[SW-1 -: RW]));
    check("c_out", SW'(c_out), SW'(e[CW-1:0]));
    check("remaining", SW'(remaining), SW'(ob));
    check("perms", SW'(perm_cnt - base_p), SW'(n + ((len >= RW) ? 1 : 0)));
    check("perm_rounds", SW'(seen_rounds), SW'(rn));
    check("out_busy", SW'(busy), SW'(1));
    for (int k = 0; k < ack_delay; k++) begin
      @(negedge clk);
      check("sv_hold", SW'(state_valid), SW'(1));
    end
    squeeze_ack = 1'b1;
    @(negedge clk);
    squeeze_ack = 1'b0;
    check("sv_drop", SW'(state_valid), SW'(0));
    check("idle_busy", SW'(busy), SW'(0));
    check("accepts", SW'(acc_cnt - base_a), SW'(n));
  endtask

  initial begin
    int t;
    reset = 1'b1;
    start = 1'b0;
    out_bits = '0;
    rounds = '0;
    msg_data = '0;
    msg_valid = 1'b0;
    msg_last = 1'b0;
    msg_len = '0;
    squeeze_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", SW'(msg_ready), SW'(0));
    check("rst_perm_go", SW'(perm_go), SW'(0));
    check("rst_sv", SW'(state_valid), SW'(0));
    check("rst_busy", SW'(busy), SW'(0));
    check("rst_r_out", SW'(r_out), SW'(0));
    check("rst_c_out", SW'(c_out), SW'(0));
    check("rst_perm_state", perm_state, SW'(0));
    check("rst_rounds", SW'(perm_rounds), SW'(0));

    perm_lat = 3;
    blk_q = {32'hAB00_0000};
    run_msg(8, 20'h00123, 10'd12, 0, 1'b0, 1'b0);
    check("t2_r_const", SW'(last_r), SW'(32'hAB80_0000));

    blk_q = {32'hA5A5_A5A5};
    run_msg(32, 20'h00100, 10'd7, 1, 1'b0, 1'b0);
    check("t3_r_const", SW'(last_r), SW'(32'h25A5_A5A5));

    blk_q = {32'hFFFF_FFFF};
    run_msg(0, 20'h00008, 10'd3, 0, 1'b0, 1'b0);
    check("t4_empty_const", SW'(last_r), SW'(32'h8000_0000));

    blk_q = {32'hA5A5_A5A5};
    run_msg(40, 20'h00100, 10'd7, 0, 1'b0, 1'b0);
    check("t4_len40_const", SW'(last_r), SW'(32'h25A5_A5A5));

    perm_lat = 5;
    blk_q = {32'h1234_5678};
    run_msg(16, 20'h00040, 10'd24, 10, 1'b1, 1'b0);

    // reset (with start) while a permutation is outstanding
    perm_lat = 20;
    start_msg(20'h00011, 10'd5);
    msg_data = 32'hCAFE_F00D;
    msg_last = 1'b0;
    msg_valid = 1'b1;
    t = 0;
    while (!msg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    msg_valid = 1'b0;
    @(negedge clk);
    check("t6_in_perm", SW'(perm_go), SW'(1));
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("t6_rst_busy", SW'(busy), SW'(0));
    check("t6_rst_perm_go", SW'(perm_go), SW'(0));
    check("t6_rst_ready", SW'(msg_ready), SW'(0));
    @(negedge clk);
    check("t6_rst_stay_idle", SW'(busy), SW'(0));

    perm_lat = 6;
    blk_q = {32'h0F0F_0F0F, 32'h9999_0000};
    run_msg(8, 20'h00077, 10'd9, 0, 1'b0, 1'b1);

    // random messages, non-trivial permutation and spurious perm_done
    perm_rot = 1'b1;
    spur_en = 1'b1;
    for (int m = 0; m < 40; m++) begin
      int nb;
      blk_q.delete();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) blk_q.push_back($urandom);
      perm_lat = $urandom_range(1, 4);
      run_msg($urandom_range(0, 40), REMW'($urandom), RC'($urandom),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
